txn_master: RTL and testbench
=============================

# txn_master

Synthesizable initiator for the single-word txn_req/txn_rdy memory transaction interface used by fabric. It accepts a block command (read or write, base address, word count). It issues one word transaction at a time, advancing the address by 4 each word. Read data leaves through a valid/ready stream; write data enters through one. The fabric uses it to fetch cost maps from 0x40000000 and to store path results at 0x40002000.

## Interface
- ADDR_W, 32, transaction address width
- DATA_W, 32, word width
- LEN_W, 9, command length width (1..2^LEN_W-1 words)
- TIMEOUT, 64, max cycles in WAIT before abort; 0 disables the watchdog
- clk  in  1  system clock, all state on posedge
- arst_n  in  1  one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write block, 0 = read block
- cmd_addr  in  ADDR_W  byte address of the first word
- cmd_len  in  LEN_W  word count
- rd_valid / rd_ready  out / in  1  read stream handshake
- rd_data  out  DATA_W  read word
- wr_valid / wr_ready  in / out  1  write stream handshake
- wr_data  in  DATA_W  write word
- txn_req  out  1  one-cycle transaction strobe
- txn_wr  out  1  transaction direction
- txn_addr  out  ADDR_W  word address
- txn_wdata  out  DATA_W  write word
- txn_rdata  in  DATA_W  read word, valid when txn_rdy returns high
- txn_rdy  in  1  responder idle/complete
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse when a block ends
- err  out  1  set on timeout or zero length; cleared by the next accepted command

## Operation
- States: IDLE, PULL, ISSUE, WAIT, PUSH, DONE.
- IDLE: when cmd_valid && cmd_ready, latch wr, addr, len. Set remaining count = len and clear err.
  - If len == 0, go to DONE with err = 1.
  - Else a write goes to PULL and a read goes to ISSUE.
- PULL: wr_ready = 1. When wr_valid, latch wr_data into txn_wdata and go to ISSUE.
- ISSUE: txn_req = 1 for exactly one cycle, only if txn_rdy == 1; otherwise hold in ISSUE. Go to WAIT.
- WAIT: txn_rdy is ignored in the first WAIT cycle, because the responder lowers rdy one cycle after sampling req. After that, txn_rdy == 1 completes the word.
  - A read latches txn_rdata into rd_data and goes to PUSH.
  - A write decrements the count and adds 4 to the address, then goes to PULL if the count is nonzero, else DONE.
- PUSH: rd_valid = 1, with rd_data held stable. When rd_ready, decrement the count and add 4 to the address, then go to ISSUE if the count is nonzero, else DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- Watchdog: counts cycles in WAIT. When it reaches TIMEOUT, set err = 1, go to DONE, and drop the remaining words. No further txn_req is issued for that block.
- txn_wr and txn_addr are held stable from ISSUE through the end of WAIT.
- The address wraps modulo 2^ADDR_W. No range checking.
- Reset mid-block: all state is cleared immediately and no done pulse is produced. Any transaction already in flight at the responder is abandoned.

## Timing
- Reset values: cmd_ready = 1 after reset release (IDLE). All of busy, done, err, txn_req, txn_wr, rd_valid and wr_ready are 0. txn_addr, txn_wdata and rd_data are 0.
- Command accept to first txn_req: 1 cycle for a read. For a write, 1 cycle after wr_valid is seen in PULL.
- Per-word cost: 1 (ISSUE) + responder latency + 1 (PUSH or PULL) when the stream side never stalls.
- One transaction is outstanding at most. txn_req is never asserted twice without an intervening completion.
- A back-to-back command is accepted no earlier than the cycle after the done pulse.

## Structure
- Package txn_pkg holds:
  - the state enum;
  - WORD_STRIDE = 4;
  - COST_BASE = 32'h40000000 and PATH_BASE = 32'h40002000, for fabric use.
- One sub-module: txn_watchdog, a loadable down-counter with an expired flag, cleared on leaving WAIT.

## Test plan
- Read len 4 at 0x40000000, with a 4-cycle-latency responder preloaded 0x11, 0x22, 0x33, 0x44 and rd_ready tied high:
  - rd stream yields 0x11, 0x22, 0x33, 0x44;
  - txn_addr goes 0x40000000, +4, +8, +C;
  - exactly 4 req pulses, then one done pulse with err = 0.
- Write len 3 at 0x40002000 with data 0xA, 0xB, 0xC, wr_valid gapped 2 cycles between words:
  - responder memory words 0..2 = 0xA, 0xB, 0xC;
  - txn_req is never high while txn_rdy is low.
- Read len 2 with rd_ready low for 10 cycles on word 0:
  - rd_data holds stable;
  - no second txn_req until the handshake completes.
- cmd_len 0 -> done pulse 1 cycle after accept, err = 1, no txn_req.
- Responder never raises rdy, TIMEOUT = 64 -> err = 1 and done exactly 64 WAIT cycles later; the next command clears err.
- arst_n pulsed low during WAIT of a 4-word read -> all outputs return to reset values, no done; a new command then completes normally.

Source files
------------

// File: rtl/txn_pkg.sv
// txn_pkg: shared types and constants for the txn_master block.
//   txn_state_e  : block-transfer FSM states
//   WORD_STRIDE  : byte increment between consecutive words
//   COST_BASE    : fabric cost-map region base
//   PATH_BASE    : fabric path-result region base
package txn_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPull,
      StIssue,
      StWait,
      StPush,
      StDone
   } txn_state_e;

   localparam int unsigned WORD_STRIDE = 4;

   localparam logic [31:0] COST_BASE = 32'h4000_0000;
   localparam logic [31:0] PATH_BASE = 32'h4000_2000;

endpackage

// File: rtl/txn_watchdog.sv
// txn_watchdog: loadable down-counter guarding the WAIT state.
//   clk, arst_n : clock, asynchronous active-low reset
//   i_load      : load TIMEOUT-1 (asserted on the cycle the transaction is issued)
//   i_run       : counting enable (high while waiting for the responder)
//   i_clear     : force the counter to zero (high whenever not waiting)
//   o_expired   : high in the TIMEOUT-th waiting cycle; never high when TIMEOUT == 0
module txn_watchdog
   import txn_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic arst_n,
   input  logic i_load,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Counter holds the number of waiting cycles still allowed after the current one.
   localparam logic [CNT_W-1:0] LOAD_VAL = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expired = (TIMEOUT != 0) && i_run && (r_cnt == '0);

endmodule

// File: rtl/txn_master.sv
// txn_master: block initiator for the single-word txn_req/txn_rdy interface.
// A command (read/write, base address, word count) is split into one-word
// transactions at consecutive word addresses, one outstanding at a time.
//   clk, arst_n                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_wr,
//   cmd_addr, cmd_len                   : block command (ready only when idle)
//   rd_valid/rd_ready, rd_data          : read-data output stream
//   wr_valid/wr_ready, wr_data          : write-data input stream
//   txn_req, txn_wr, txn_addr,
//   txn_wdata, txn_rdata, txn_rdy       : responder interface
//   busy, done, err                     : status (done is a one-cycle pulse)
module txn_master
   import txn_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LEN_W   = 9,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              arst_n,
   // command
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   // read stream
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   // write stream
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   // responder
   output logic              txn_req,
   output logic              txn_wr,
   output logic [ADDR_W-1:0] txn_addr,
   output logic [DATA_W-1:0] txn_wdata,
   input  logic [DATA_W-1:0] txn_rdata,
   input  logic              txn_rdy,
   // status
   output logic              busy,
   output logic              done,
   output logic              err
);

   txn_state_e        r_state;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_err;
   logic              r_wait_first;

   logic              w_expired;
   logic              w_waiting;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr_next;

   assign w_waiting   = (r_state == StWait);
   assign w_last      = (r_cnt == LEN_W'(1));
   assign w_addr_next = r_addr + ADDR_W'(WORD_STRIDE);  // wraps modulo 2^ADDR_W

   txn_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_load    (txn_req),
      .i_run     (w_waiting),
      .i_clear   (!w_waiting),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state      <= StIdle;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_wdata      <= '0;
         r_rd_data    <= '0;
         r_err        <= 1'b0;
         r_wait_first <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (cmd_valid) begin
                  r_wr   <= cmd_wr;
                  r_addr <= cmd_addr;
                  r_cnt  <= cmd_len;
                  r_err  <= 1'b0;
                  if (cmd_len == '0) begin
                     r_err   <= 1'b1;
                     r_state <= StDone;
                  end else begin
                     r_state <= cmd_wr ? StPull : StIssue;
                  end
               end
            end
            StPull: begin
               if (wr_valid) begin
                  r_wdata <= wr_data;
                  r_state <= StIssue;
               end
            end
            StIssue: begin
               // txn_req is only driven while txn_rdy is high, so this is the strobe cycle.
               if (txn_rdy) begin
                  r_wait_first <= 1'b1;
                  r_state      <= StWait;
               end
            end
            StWait: begin
               r_wait_first <= 1'b0;
               // The responder still shows its idle rdy in the cycle right after the strobe.
               if (!r_wait_first && txn_rdy) begin
                  if (r_wr) begin
                     r_cnt   <= r_cnt - 1'b1;
                     r_addr  <= w_addr_next;
                     r_state <= w_last ? StDone : StPull;
                  end else begin
                     r_rd_data <= txn_rdata;
                     r_state   <= StPush;
                  end
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= StDone;
               end
            end
            StPush: begin
               if (rd_ready) begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_addr  <= w_addr_next;
                  r_state <= w_last ? StDone : StIssue;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == StIdle);
   assign busy      = (r_state != StIdle);
   assign wr_ready  = (r_state == StPull);
   assign rd_valid  = (r_state == StPush);
   assign done      = (r_state == StDone);
   assign txn_req   = (r_state == StIssue) && txn_rdy;
   assign txn_wr    = r_wr;
   assign txn_addr  = r_addr;
   assign txn_wdata = r_wdata;
   assign rd_data   = r_rd_data;
   assign err       = r_err;

endmodule

// File: tb/tb_txn_master.sv
// tb_txn_master: scoreboard bench for txn_master with a latency-programmable responder.
module tb_txn_master;
   import txn_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int LEN_W   = 9;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 4;

   logic              clk;
   logic              arst_n;
   logic              cmd_valid, cmd_ready, cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              rd_valid, rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              wr_valid, wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              txn_req, txn_wr;
   logic [ADDR_W-1:0] txn_addr;
   logic [DATA_W-1:0] txn_wdata, txn_rdata;
   logic              txn_rdy;
   logic              busy, done, err;

   txn_master #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .txn_req   (txn_req),
      .txn_wr    (txn_wr),
      .txn_addr  (txn_addr),
      .txn_wdata (txn_wdata),
      .txn_rdata (txn_rdata),
      .txn_rdy   (txn_rdy),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- responder model ----------------
   logic [31:0] rom  [16];  // read source
   logic [31:0] wmem [16];  // write sink
   logic        rsp_busy;
   logic        rsp_wr;
   logic [3:0]  rsp_idx;
   logic [31:0] rsp_wdata;
   int          rsp_lat;
   logic        hang;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         txn_rdy   <= 1'b1;
         txn_rdata <= '0;
         rsp_busy  <= 1'b0;
         rsp_lat   <= 0;
      end else if (!rsp_busy) begin
         if (txn_req && txn_rdy) begin
            rsp_busy  <= 1'b1;
            txn_rdy   <= 1'b0;
            rsp_lat   <= LAT - 1;
            rsp_wr    <= txn_wr;
            rsp_idx   <= txn_addr[5:2];
            rsp_wdata <= txn_wdata;
         end
      end else if (!hang) begin
         if (rsp_lat == 0) begin
            if (rsp_wr) wmem[rsp_idx] <= rsp_wdata;
            else        txn_rdata <= rom[rsp_idx];
            txn_rdy  <= 1'b1;
            rsp_busy <= 1'b0;
         end else begin
            rsp_lat <= rsp_lat - 1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_rd_q[$];
   int   cyc = 0;
   int   req_cnt = 0, done_cnt = 0, viol_cnt = 0, extra_req = 0, extra_rd = 0;
   int   req_cyc = 0, done_cyc = 0;
   logic done_err = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (arst_n) begin
         if (txn_req) begin
            req_cnt++;
            req_cyc = cyc;
            if (!txn_rdy) viol_cnt++;
            if (exp_addr_q.size() > 0) check_eq("txn_addr", txn_addr, exp_addr_q.pop_front());
            else extra_req++;
         end
         if (rd_valid && rd_ready) begin
            if (exp_rd_q.size() > 0) check_eq("rd_data", rd_data, exp_rd_q.pop_front());
            else extra_rd++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [LEN_W-1:0] len);
      int n = 0;
      while (!cmd_ready && n < 300) begin
         step();
         n++;
      end
      if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int prev, input int limit);
      int n = 0;
      while (done_cnt == prev && n < limit) begin
         step();
         n++;
      end
      if (done_cnt == prev) check_eq("done_wait", 32'(done_cnt), 32'(prev + 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_flags"},
               32'({cmd_ready, busy, done, err, txn_req, txn_wr, rd_valid, wr_ready}), 32'h80);
      check_eq({tag, "_addr"}, txn_addr, 32'h0);
      check_eq({tag, "_wdata"}, txn_wdata, 32'h0);
      check_eq({tag, "_rdata"}, rd_data, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int r0, d0, v0, n;
      logic [31:0] wd [3];
      wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;

      arst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0; hang = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 32'h0;
      rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
      rom[4] = 32'h55; rom[5] = 32'h66; rom[6] = 32'h5A;
      rom[8] = 32'h77; rom[9] = 32'h88; rom[10] = 32'h99; rom[11] = 32'hAA;

      repeat (3) step();
      arst_n = 1'b1;
      step();
      check_reset_outputs("reset");

      // 1: read 4 words from the cost-map base
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(COST_BASE + 32'(4 * i));
         exp_rd_q.push_back(rom[i]);
      end
      rd_ready = 1'b1;
      r0 = req_cnt; d0 = done_cnt;
      send_cmd(1'b0, COST_BASE, 9'd4);
      check_eq("rd_req_latency", 32'(txn_req), 32'd1);
      wait_done(d0, 300);
      repeat (3) step();
      check_eq("rd_req_count", 32'(req_cnt - r0), 32'd4);
      check_eq("rd_done_count", 32'(done_cnt - d0), 32'd1);
      check_eq("rd_err", 32'(done_err), 32'd0);
      check_eq("rd_left", 32'(exp_rd_q.size()), 32'd0);

      // 2: write 3 words to the path base with gapped write stream
      for (int i = 0; i < 3; i++) exp_addr_q.push_back(PATH_BASE + 32'(4 * i));
      r0 = req_cnt; d0 = done_cnt; v0 = viol_cnt;
      send_cmd(1'b1, PATH_BASE, 9'd3);
      for (int i = 0; i < 3; i++) begin
         wr_data  = wd[i];
         wr_valid = 1'b1;
         n = 0;
         while (!wr_ready && n < 300) begin
            step();
            n++;
         end
         if (!wr_ready) check_eq("wr_ready_wait", 32'(wr_ready), 32'd1);
         step();
         wr_valid = 1'b0;
         step();
         step();
      end
      wait_done(d0, 300);
      for (int i = 0; i < 3; i++) check_eq("wr_mem", wmem[i], wd[i]);
      check_eq("wr_req_count", 32'(req_cnt - r0), 32'd3);
      check_eq("wr_err", 32'(done_err), 32'd0);
      check_eq("wr_req_vs_rdy", 32'(viol_cnt - v0), 32'd0);

      // 3: read 2 words with rd_ready held low on word 0
      exp_addr_q.push_back(COST_BASE + 32'h10);
      exp_addr_q.push_back(COST_BASE + 32'h14);
      exp_rd_q.push_back(32'h55);
      exp_rd_q.push_back(32'h66);
      rd_ready = 1'b0;
      r0 = req_cnt; d0 = done_cnt;
      send_cmd(1'b0, COST_BASE + 32'h10, 9'd2);
      n = 0;
      while (!rd_valid && n < 100) begin
         step();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         check_eq("stall_rd_data", rd_data, 32'h55);
         check_eq("stall_no_req", 32'(req_cnt - r0), 32'd1);
         step();
      end
      rd_ready = 1'b1;
      wait_done(d0, 300);
      check_eq("stall_req_count", 32'(req_cnt - r0), 32'd2);
      check_eq("stall_left", 32'(exp_rd_q.size()), 32'd0);

      // 4: zero-length command
      r0 = req_cnt; d0 = done_cnt;
      send_cmd(1'b0, COST_BASE, 9'd0);
      check_eq("zero_done_err", 32'({done, err}), 32'b11);
      wait_done(d0, 20);
      repeat (3) step();
      check_eq("zero_no_req", 32'(req_cnt - r0), 32'd0);

      // 5: responder never completes -> watchdog abort, next command clears err
      hang = 1'b1;
      exp_addr_q.push_back(COST_BASE);
      r0 = req_cnt; d0 = done_cnt;
      send_cmd(1'b0, COST_BASE, 9'd1);
      wait_done(d0, 400);
      check_eq("to_wait_cycles", 32'(done_cyc - req_cyc), 32'(TIMEOUT + 1));
      check_eq("to_err", 32'(done_err), 32'd1);
      check_eq("to_req_count", 32'(req_cnt - r0), 32'd1);
      hang = 1'b0;
      exp_addr_q.push_back(COST_BASE + 32'h18);
      exp_rd_q.push_back(32'h5A);
      d0 = done_cnt;
      send_cmd(1'b0, COST_BASE + 32'h18, 9'd1);
      check_eq("to_err_cleared", 32'(err), 32'd0);
      wait_done(d0, 300);
      check_eq("to_next_err", 32'(done_err), 32'd0);

      // 6: asynchronous reset during WAIT of a 4-word read
      for (int i = 0; i < 4; i++) exp_addr_q.push_back(COST_BASE + 32'h20 + 32'(4 * i));
      r0 = req_cnt; d0 = done_cnt;
      send_cmd(1'b0, COST_BASE + 32'h20, 9'd4);
      n = 0;
      while (req_cnt == r0 && n < 50) begin
         step();
         n++;
      end
      step();
      step();
      arst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      exp_addr_q.delete();
      exp_rd_q.delete();
      step();
      step();
      arst_n = 1'b1;
      step();
      check_reset_outputs("rst_rel");
      repeat (5) step();
      check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
      exp_addr_q.push_back(COST_BASE + 32'h20);
      exp_addr_q.push_back(COST_BASE + 32'h24);
      exp_rd_q.push_back(32'h77);
      exp_rd_q.push_back(32'h88);
      r0 = req_cnt;
      send_cmd(1'b0, COST_BASE + 32'h20, 9'd2);
      wait_done(d0, 300);
      check_eq("rst_after_err", 32'(done_err), 32'd0);
      check_eq("rst_after_reqs", 32'(req_cnt - r0), 32'd2);

      // global invariants
      repeat (3) step();
      check_eq("req_while_busy", 32'(viol_cnt), 32'd0);
      check_eq("unexpected_req", 32'(extra_req), 32'd0);
      check_eq("unexpected_rd", 32'(extra_rd), 32'd0);
      check_eq("addr_left", 32'(exp_addr_q.size()), 32'd0);
      check_eq("rd_q_left", 32'(exp_rd_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
